tri_pixel_collector: RTL and testbench

- Downstream stage of the triangle rasterizer.
- Consumes the rasterizer's point stream (po/xo/yo, framed by busy) and accumulates it into a GRID x GRID occupancy bitmap.
- Collects per-triangle statistics: pixel count, duplicate count and bounding box.
- When the triangle is complete, drains the bitmap one row per valid/ready handshake to the frame-store/display path, then returns to idle with the bitmap cleared.

---
 rtl/tri_pixel_collector_pkg.sv | 25 ++
 rtl/tri_pixel_collector_bbox.sv | 57 +++++
 rtl/tri_pixel_collector.sv | 172 +++++++++++++++++
 tb/tb_tri_pixel_collector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pixel_collector_pkg.sv
// Shared types and constants for the raster point-collector path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tri_pixel_collector_pkg;

    localparam int W_DEF    = 3;
    localparam int GRID_DEF = 1 << W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // The bounding box starts "inverted" so the first point sets both min and max.
    function automatic int bbox_min_rst(input int grid);
        return grid - 1;
    endfunction

    function automatic int bbox_max_rst(input int grid);
        return (grid > 0) ? 0 : 0;
    endfunction

endpackage

// File: rtl/tri_pixel_collector_bbox.sv
// Min/max bounding-box tracker with clear and point-update strobes.
// Latency: result visible the cycle after i_upd.
// Backpressure: none; accepts an update every cycle.
import tri_pixel_collector_pkg::*;

module tri_bbox_tracker #(
    parameter int W    = W_DEF,
    parameter int GRID = 1 << W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_upd,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_xmin,
    output logic [W-1:0] o_xmax,
    output logic [W-1:0] o_ymin,
    output logic [W-1:0] o_ymax
);

    localparam logic [W-1:0] MIN_RST = W'(bbox_min_rst(GRID));
    localparam logic [W-1:0] MAX_RST = W'(bbox_max_rst(GRID));

    logic [W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;

    // Clear takes priority; a point arriving with the clear seeds the box directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xmin <= MIN_RST;
            r_xmax <= MAX_RST;
            r_ymin <= MIN_RST;
            r_ymax <= MAX_RST;
        end else if (i_clear && i_upd) begin
            r_xmin <= i_x;
            r_xmax <= i_x;
            r_ymin <= i_y;
            r_ymax <= i_y;
        end else if (i_clear) begin
            r_xmin <= MIN_RST;
            r_xmax <= MAX_RST;
            r_ymin <= MIN_RST;
            r_ymax <= MAX_RST;
        end else if (i_upd) begin
            if (i_x < r_xmin) r_xmin <= i_x;
            if (i_x > r_xmax) r_xmax <= i_x;
            if (i_y < r_ymin) r_ymin <= i_y;
            if (i_y > r_ymax) r_ymax <= i_y;
        end
    end

    assign o_xmin = r_xmin;
    assign o_xmax = r_xmax;
    assign o_ymin = r_ymin;
    assign o_ymax = r_ymax;

endmodule

// File: rtl/tri_pixel_collector.sv
// Accumulates rasterizer points into a GRID x GRID bitmap with stats, then drains it row by row.
// Latency: first row valid 1 cycle after busy_i sampled low; GRID cycles minimum drain; done 1 cycle after last accept.
// Backpressure: row held stable while row_valid_o && !row_ready_i; accept_o low tells upstream to hold off new triangles.
import tri_pixel_collector_pkg::*;

module tri_pixel_collector #(
    parameter int W    = W_DEF,
    parameter int GRID = 1 << W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            busy_i,
    input  logic            po_i,
    input  logic [W-1:0]    xo_i,
    input  logic [W-1:0]    yo_i,
    output logic            accept_o,
    output logic            row_valid_o,
    input  logic            row_ready_i,
    output logic [W-1:0]    row_idx_o,
    output logic [GRID-1:0] row_data_o,
    output logic            done_o,
    output logic [2*W:0]    pix_cnt_o,
    output logic [2*W-1:0]  dup_cnt_o,
    output logic [W-1:0]    xmin_o,
    output logic [W-1:0]    xmax_o,
    output logic [W-1:0]    ymin_o,
    output logic [W-1:0]    ymax_o,
    output logic            empty_o,
    output logic            overrun_o
);

    localparam int           PIX_W    = 2 * W + 1;
    localparam int           DUP_W    = 2 * W;
    localparam logic [W-1:0] ROW_LAST = W'(GRID - 1);

    state_t              r_state, w_state_nxt;
    logic [GRID-1:0]     r_bitmap [GRID];
    logic [W-1:0]        r_row_idx;
    logic [PIX_W-1:0]    r_pix_cnt;
    logic [DUP_W-1:0]    r_dup_cnt;
    logic                r_empty;
    logic                r_overrun;

    logic                w_frame_start;
    logic                w_cap;
    logic                w_collecting;
    logic                w_draining;
    logic                w_hit;
    logic                w_new;
    logic                w_dup;
    logic                w_row_acc;
    logic [PIX_W-1:0]    w_pix_base, w_pix_nxt;
    logic [DUP_W-1:0]    w_dup_base, w_dup_nxt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt   = r_state;
        accept_o      = 1'b0;
        row_valid_o   = 1'b0;
        done_o        = 1'b0;
        w_frame_start = 1'b0;
        w_collecting  = 1'b0;
        w_draining    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                accept_o     = 1'b1;
                w_collecting = 1'b1;
                if (busy_i || po_i) begin
                    w_frame_start = 1'b1;
                    w_state_nxt   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                accept_o     = 1'b1;
                w_collecting = 1'b1;
                if (!busy_i) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                row_valid_o = 1'b1;
                w_draining  = 1'b1;
                if (row_ready_i && (r_row_idx == ROW_LAST)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_draining  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Point classification; in IDLE the bitmap is already clear, so the start-cycle point is always new.
    assign w_cap     = po_i && w_collecting;
    assign w_hit     = r_bitmap[yo_i][xo_i];
    assign w_new     = w_cap && !w_hit;
    assign w_dup     = w_cap && w_hit;
    assign w_row_acc = row_valid_o && row_ready_i;

    // Frame start zeroes the counters before the same-cycle point is counted.
    assign w_pix_base = w_frame_start ? '0 : r_pix_cnt;
    assign w_dup_base = w_frame_start ? '0 : r_dup_cnt;
    assign w_pix_nxt  = w_pix_base + {{(PIX_W-1){1'b0}}, w_new};
    assign w_dup_nxt  = (w_dup && (w_dup_base != {DUP_W{1'b1}})) ? w_dup_base + DUP_W'(1) : w_dup_base;

    // Bitmap: set on new points while collecting, clear each row as it is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < GRID; i++) r_bitmap[i] <= '0;
        end else if (w_new) begin
            r_bitmap[yo_i][xo_i] <= 1'b1;
        end else if (w_row_acc) begin
            r_bitmap[r_row_idx] <= '0;
        end
    end

    // Row pointer advances per accepted row and wraps to 0 after the last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_row_idx <= '0;
        else if (w_row_acc) r_row_idx <= r_row_idx + W'(1);
    end

    // Per-triangle counters and flags; they hold through DRAIN/DONE until the next frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_cnt <= '0;
            r_dup_cnt <= '0;
            r_empty   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pix_cnt <= w_pix_nxt;
            r_dup_cnt <= w_dup_nxt;
            if (w_frame_start)
                r_empty <= 1'b0;
            else if ((r_state == ST_COLLECT) && !busy_i)
                r_empty <= (w_pix_nxt == '0);
            if (w_frame_start)
                r_overrun <= 1'b0;
            else if (w_draining && po_i)
                r_overrun <= 1'b1;
        end
    end

    tri_bbox_tracker #(
        .W    (W),
        .GRID (GRID)
    ) u_bbox (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_frame_start),
        .i_upd   (w_new),
        .i_x     (xo_i),
        .i_y     (yo_i),
        .o_xmin  (xmin_o),
        .o_xmax  (xmax_o),
        .o_ymin  (ymin_o),
        .o_ymax  (ymax_o)
    );

    assign row_idx_o  = r_row_idx;
    assign row_data_o = r_bitmap[r_row_idx];
    assign pix_cnt_o  = r_pix_cnt;
    assign dup_cnt_o  = r_dup_cnt;
    assign empty_o    = r_empty;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed self-checking bench for tri_pixel_collector (W=3, GRID=8).
// Latency: n/a.
// Backpressure: exercised by toggling row_ready_i during a drain.
module tb_tri_pixel_collector;

    localparam int W    = 3;
    localparam int GRID = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            busy_i, po_i, row_ready_i;
    logic [W-1:0]    xo_i, yo_i;
    logic            accept_o, row_valid_o, done_o, empty_o, overrun_o;
    logic [W-1:0]    row_idx_o, xmin_o, xmax_o, ymin_o, ymax_o;
    logic [GRID-1:0] row_data_o;
    logic [2*W:0]    pix_cnt_o;
    logic [2*W-1:0]  dup_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [GRID-1:0] exp_rows [GRID];

    tri_pixel_collector #(.W(W), .GRID(GRID)) dut (
        .clk         (clk),
        .reset       (reset),
        .busy_i      (busy_i),
        .po_i        (po_i),
        .xo_i        (xo_i),
        .yo_i        (yo_i),
        .accept_o    (accept_o),
        .row_valid_o (row_valid_o),
        .row_ready_i (row_ready_i),
        .row_idx_o   (row_idx_o),
        .row_data_o  (row_data_o),
        .done_o      (done_o),
        .pix_cnt_o   (pix_cnt_o),
        .dup_cnt_o   (dup_cnt_o),
        .xmin_o      (xmin_o),
        .xmax_o      (xmax_o),
        .ymin_o      (ymin_o),
        .ymax_o      (ymax_o),
        .empty_o     (empty_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rows();
        for (int r = 0; r < GRID; r++) exp_rows[r] = '0;
    endtask

    task automatic start_frame();
        busy_i = 1'b1;
        step();
        chk("start_accept", accept_o, 1);
    endtask

    task automatic add_pt(input logic [W-1:0] x, input logic [W-1:0] y);
        po_i = 1'b1;
        xo_i = x;
        yo_i = y;
        step();
        po_i = 1'b0;
    endtask

    task automatic end_frame();
        busy_i = 1'b0;
        step();
        chk("end_row_vld", row_valid_o, 1);
        chk("end_accept", accept_o, 0);
    endtask

    task automatic chk_stats(input int pix, input int dup, input int xmn, input int xmx,
                             input int ymn, input int ymx, input int emp);
        chk("pix_cnt", pix_cnt_o, pix);
        chk("dup_cnt", dup_cnt_o, dup);
        chk("xmin", xmin_o, xmn);
        chk("xmax", xmax_o, xmx);
        chk("ymin", ymin_o, ymn);
        chk("ymax", ymax_o, ymx);
        chk("empty", empty_o, emp);
    endtask

    // Drain all rows against exp_rows; with bp set, each row sits one cycle un-accepted first.
    task automatic drain(input bit bp);
        for (int r = 0; r < GRID; r++) begin
            chk($sformatf("row_vld%0d", r), row_valid_o, 1);
            chk($sformatf("row_idx%0d", r), row_idx_o, r);
            chk($sformatf("row_dat%0d", r), row_data_o, exp_rows[r]);
            chk($sformatf("no_done%0d", r), done_o, 0);
            if (bp) begin
                row_ready_i = 1'b0;
                step();
                chk($sformatf("hold_idx%0d", r), row_idx_o, r);
                chk($sformatf("hold_dat%0d", r), row_data_o, exp_rows[r]);
            end
            row_ready_i = 1'b1;
            step();
        end
        row_ready_i = 1'b0;
        chk("done_pulse", done_o, 1);
        chk("done_vld", row_valid_o, 0);
        chk("done_idx", row_idx_o, 0);
        step();
        chk("done_low", done_o, 0);
        chk("idle_accept", accept_o, 1);
    endtask

    initial begin
        reset       = 1'b1;
        busy_i      = 1'b0;
        po_i        = 1'b0;
        row_ready_i = 1'b0;
        xo_i        = '0;
        yo_i        = '0;
        step();
        step();
        chk("rst_accept", accept_o, 1);
        chk("rst_vld", row_valid_o, 0);
        chk("rst_idx", row_idx_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovr", overrun_o, 0);
        chk_stats(0, 0, 7, 0, 7, 0, 0);
        reset = 1'b0;
        step();

        // Three-point triangle.
        clear_rows();
        exp_rows[0] = 8'h02;
        exp_rows[1] = 8'h06;
        start_frame();
        add_pt(3'd1, 3'd0);
        add_pt(3'd1, 3'd1);
        add_pt(3'd2, 3'd1);
        end_frame();
        chk_stats(3, 0, 1, 2, 0, 1, 0);
        drain(1'b0);

        // Duplicate point.
        clear_rows();
        exp_rows[3] = 8'h18;
        start_frame();
        add_pt(3'd3, 3'd3);
        add_pt(3'd3, 3'd3);
        add_pt(3'd4, 3'd3);
        end_frame();
        chk_stats(2, 1, 3, 4, 3, 3, 0);
        drain(1'b0);

        // Backpressured drain.
        clear_rows();
        exp_rows[0] = 8'h01;
        exp_rows[2] = 8'h20;
        exp_rows[7] = 8'h80;
        start_frame();
        add_pt(3'd0, 3'd0);
        add_pt(3'd7, 3'd7);
        add_pt(3'd5, 3'd2);
        end_frame();
        chk_stats(3, 0, 0, 7, 0, 7, 0);
        drain(1'b1);

        // Empty frame; also shows the previous drain left the bitmap clear.
        clear_rows();
        start_frame();
        step();
        step();
        step();
        end_frame();
        chk_stats(0, 0, 7, 0, 7, 0, 1);
        drain(1'b0);

        // Point on the busy-low cycle is captured; po_i during DRAIN flags overrun only.
        clear_rows();
        exp_rows[5] = 8'h04;
        start_frame();
        busy_i = 1'b0;
        add_pt(3'd2, 3'd5);
        chk("ovr_vld", row_valid_o, 1);
        chk_stats(1, 0, 2, 2, 5, 5, 0);
        chk("ovr_pre", overrun_o, 0);
        row_ready_i = 1'b0;
        add_pt(3'd6, 3'd5);
        chk("ovr_set", overrun_o, 1);
        chk("ovr_idx", row_idx_o, 0);
        chk("ovr_pix", pix_cnt_o, 1);
        drain(1'b0);
        chk("ovr_sticky", overrun_o, 1);

        // Next frame clears overrun; reset lands mid-drain at row 4.
        start_frame();
        chk("ovr_clr", overrun_o, 0);
        add_pt(3'd1, 3'd6);
        end_frame();
        for (int r = 0; r < 4; r++) begin
            row_ready_i = 1'b1;
            step();
        end
        row_ready_i = 1'b0;
        chk("pre_rst_idx", row_idx_o, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_accept", accept_o, 1);
        chk("mid_rst_vld", row_valid_o, 0);
        chk("mid_rst_idx", row_idx_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_dat", row_data_o, 0);
        chk_stats(0, 0, 7, 0, 7, 0, 0);
        #2;
        reset = 1'b0;
        step();
        chk("post_rst_done", done_o, 0);

        // Start and point in the same IDLE cycle; stale row 6 must be gone.
        clear_rows();
        exp_rows[7] = 8'h80;
        busy_i = 1'b1;
        add_pt(3'd7, 3'd7);
        chk("same_cycle_pix", pix_cnt_o, 1);
        end_frame();
        chk_stats(1, 0, 7, 7, 7, 7, 0);
        drain(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
